// File: rtl/hazard_fwd_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared encodings for the ID/EX hazard and forwarding logic:
//   - fwd_sel_e : per-channel operand source (register file, EX/MEM ALU
//                 result, MEM/WB write-back data)
//   - state_e   : load-use stall state machine encoding
//   - NOP_CTRL_DEF : control bundle injected into EX for a bubble
//                    (ALUOp field = 4'b1111, everything else inactive)
//   - CNT_W     : width of the stall counter (LOAD_LAT is at most 3)
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_LDSTALL = 1'b1
  } state_e;

  localparam logic [15:0] NOP_CTRL_DEF = 16'h000F;

  localparam int CNT_W = 2;

endpackage

// File: rtl/hazard_fwd_unit_fwd_sel_ch.sv
// -----------------------------------------------------------------------------
// fwd_sel_ch
// Forwarding selector for one EX-stage source operand channel.
// Priority: EX/MEM ALU result (only when the MEM instruction is not a load,
// because a load's ALU result is an address), then MEM/WB write-back data,
// then the registered register-file value. Register 0 and channels that do
// not read a source always take the register-file value.
//
// Ports:
//   i_src          registered source register number of this channel
//   i_use          channel actually reads its source
//   i_mem_rd       EX/MEM destination
//   i_mem_regwrite EX/MEM writes a register
//   i_mem_memread  EX/MEM is a load
//   i_mem_alu      EX/MEM ALU result
//   i_wb_rd        MEM/WB destination
//   i_wb_regwrite  MEM/WB writes a register
//   i_wb_data      MEM/WB final write-back data
//   i_rf_data      registered register-file read data
//   o_opnd         forwarded operand
//   o_sel          chosen source (fwd_sel_e encoding)
// -----------------------------------------------------------------------------
module fwd_sel_ch
  import hazard_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] i_src,
  input  logic          i_use,
  input  logic [RW-1:0] i_mem_rd,
  input  logic          i_mem_regwrite,
  input  logic          i_mem_memread,
  input  logic [DW-1:0] i_mem_alu,
  input  logic [RW-1:0] i_wb_rd,
  input  logic          i_wb_regwrite,
  input  logic [DW-1:0] i_wb_data,
  input  logic [DW-1:0] i_rf_data,
  output logic [DW-1:0] o_opnd,
  output logic [1:0]    o_sel
);

  fwd_sel_e w_sel;

  always_comb begin
    w_sel = FWD_RF;
    if (i_use && (i_src != '0)) begin
      if (i_mem_regwrite && !i_mem_memread && (i_mem_rd == i_src)) begin
        w_sel = FWD_MEM;
      end else if (i_wb_regwrite && (i_wb_rd == i_src)) begin
        w_sel = FWD_WB;
      end
    end
  end

  always_comb begin
    case (w_sel)
      FWD_MEM: o_opnd = i_mem_alu;
      FWD_WB:  o_opnd = i_wb_data;
      default: o_opnd = i_rf_data;
    endcase
  end

  assign o_sel = w_sel;

endmodule

// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
// Owns the ID/EX control/address register, the load-use stall state machine
// and the EX-stage operand forwarding for NSRC source channels.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             branch/jump redirect; squash instruction entering EX
//   id_src/id_use     decode source registers (channel i at [i*RW+:RW]) and
//                     per-channel "reads its source" bits
//   id_rd/id_regwrite/id_memread/id_ctrl  decode destination and control
//   rf_data           register-file read data, registered alongside ID/EX
//   mem_*             EX/MEM destination, write enable, load flag, ALU result
//   wb_*              MEM/WB destination, write enable, write-back data
//   stall             hold PC and IF/ID
//   ex_ctrl/ex_rd/ex_regwrite/ex_memread  registered ID/EX contents
//   ex_opnd           forwarded operands, channel i at [i*DW+:DW]
//   ex_fwd_sel        per-channel source, 00 regfile / 01 mem_alu / 10 wb_data
// -----------------------------------------------------------------------------
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int                 DW       = 32,
  parameter int                 RW       = 5,
  parameter int                 NSRC     = 2,
  parameter int                 LOAD_LAT = 1,
  parameter int                 CTRL_W   = 16,
  parameter logic [CTRL_W-1:0]  NOP_CTRL = CTRL_W'(NOP_CTRL_DEF)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [NSRC*RW-1:0]   id_src,
  input  logic [NSRC-1:0]      id_use,
  input  logic [RW-1:0]        id_rd,
  input  logic                 id_regwrite,
  input  logic                 id_memread,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic [NSRC*DW-1:0]   rf_data,
  input  logic [RW-1:0]        mem_rd,
  input  logic                 mem_regwrite,
  input  logic                 mem_memread,
  input  logic [DW-1:0]        mem_alu,
  input  logic [RW-1:0]        wb_rd,
  input  logic                 wb_regwrite,
  input  logic [DW-1:0]        wb_data,
  output logic                 stall,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic [RW-1:0]        ex_rd,
  output logic                 ex_regwrite,
  output logic                 ex_memread,
  output logic [NSRC*DW-1:0]   ex_opnd,
  output logic [2*NSRC-1:0]    ex_fwd_sel
);

  // Counter value loaded on the hazard cycle: remaining extra bubbles.
  localparam logic [CNT_W-1:0] LAT_M1   = CNT_W'(LOAD_LAT - 1);
  localparam logic             LONG_LAT = (LOAD_LAT > 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;

  logic [CTRL_W-1:0]   r_ctrl;
  logic [RW-1:0]       r_rd;
  logic                r_regwrite;
  logic                r_memread;
  logic [NSRC*RW-1:0]  r_src;
  logic [NSRC-1:0]     r_use;
  logic [NSRC*DW-1:0]  r_data;

  logic                w_hit;
  logic                w_stall;
  logic                w_load_id;

  // Load-use hazard: the instruction in EX is a load whose destination is
  // read by the instruction in decode.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (id_use[i] && r_memread && (r_rd != '0) && (id_src[i*RW +: RW] == r_rd)) begin
        w_hit = 1'b1;
      end
    end
  end

  // Next-state / output logic. Flush always wins: it squashes the incoming
  // instruction and releases any pending stall in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_load_id   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (flush) begin
          w_state_nxt = ST_RUN;
        end else if (w_hit) begin
          w_stall   = 1'b1;
          w_cnt_nxt = LAT_M1;
          if (LONG_LAT) begin
            w_state_nxt = ST_LDSTALL;
          end
        end else begin
          w_load_id = 1'b1;
        end
      end
      ST_LDSTALL: begin
        if (flush) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - 1'b1;
          // The last bubble is being inserted when the counter reaches zero
          // on this edge; the held instruction issues on the following cycle.
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ID/EX register: either the decode fields or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl     <= NOP_CTRL;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_src      <= '0;
      r_use      <= '0;
      r_data     <= '0;
    end else if (w_load_id) begin
      r_ctrl     <= id_ctrl;
      r_rd       <= id_rd;
      r_regwrite <= id_regwrite;
      r_memread  <= id_memread;
      r_src      <= id_src;
      r_use      <= id_use;
      r_data     <= rf_data;
    end else begin
      r_ctrl     <= NOP_CTRL;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_src      <= '0;
      r_use      <= '0;
      r_data     <= '0;
    end
  end

  // EX stage: per-channel forwarding on the registered source/use bits.
  for (genvar g = 0; g < NSRC; g++) begin : g_ch
    logic [DW-1:0] w_opnd;
    logic [1:0]    w_sel;

    fwd_sel_ch #(
      .DW (DW),
      .RW (RW)
    ) u_fwd (
      .i_src          (r_src[g*RW +: RW]),
      .i_use          (r_use[g]),
      .i_mem_rd       (mem_rd),
      .i_mem_regwrite (mem_regwrite),
      .i_mem_memread  (mem_memread),
      .i_mem_alu      (mem_alu),
      .i_wb_rd        (wb_rd),
      .i_wb_regwrite  (wb_regwrite),
      .i_wb_data      (wb_data),
      .i_rf_data      (r_data[g*DW +: DW]),
      .o_opnd         (w_opnd),
      .o_sel          (w_sel)
    );

    assign ex_opnd[g*DW +: DW]  = w_opnd;
    assign ex_fwd_sel[g*2 +: 2] = w_sel;
  end

  assign stall       = w_stall;
  assign ex_ctrl     = r_ctrl;
  assign ex_rd       = r_rd;
  assign ex_regwrite = r_regwrite;
  assign ex_memread  = r_memread;

endmodule
